// File: rtl/xosera_bus_pkg.sv
// Shared types and constants for the Xosera register-bus master.
// The byte helper picks the byte a write drives for a given phase.
package xosera_bus_pkg;

    localparam int REG_W  = 4;
    localparam int DATA_W = 16;

    localparam logic BYTESEL_HI = 1'b0;
    localparam logic BYTESEL_LO = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP
    } state_t;

    // Reads drive zero onto the data bus.
    function automatic logic [7:0] bus_byte(input logic wr, input logic lo,
                                            input logic [DATA_W-1:0] d);
        logic [7:0] b;
        b = 8'h00;
        if (wr) begin
            b = lo ? d[7:0] : d[15:8];
        end
        return b;
    endfunction

endpackage

// File: rtl/xosera_bus_master_rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or after the pointer.
// The pointer moves past the granted index only when advance_i is asserted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] gidx;
    logic             found;
    int               idx;

    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                grant[idx] = 1'b1;
                gidx       = IDX_W'(idx);
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o     = grant;
    assign grant_idx_o = gidx;

endmodule

// File: rtl/xosera_bus_master.sv
// Arbitrates requesters onto the Xosera byte-wide register bus and sequences
// each access as SETUP/STROBE/HOLD byte phases, returning a one-cycle response.
module xosera_bus_master
    import xosera_bus_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ-1:0]         req_wr_i,
    input  logic [NUM_REQ-1:0]         req_byte_i,
    input  logic [NUM_REQ*4-1:0]       req_reg_i,
    input  logic [NUM_REQ*16-1:0]      req_data_i,
    output logic                       rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [15:0]                rsp_data_o,
    output logic                       busy_o,
    output logic                       bus_cs_n_o,
    output logic                       bus_rd_nwr_o,
    output logic [3:0]                 bus_reg_num_o,
    output logic                       bus_bytesel_o,
    output logic [7:0]                 bus_data_o,
    input  logic [7:0]                 bus_data_i
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    // With no setup phase each byte starts directly in STROBE with cs_n low.
    localparam state_t FIRST_ST   = (SETUP_CYC > 0) ? ST_SETUP : ST_STROBE;
    localparam logic   FIRST_CS_N = (SETUP_CYC > 0);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 cs_n_q, cs_n_d;
    logic                 rd_nwr_q, rd_nwr_d;
    logic [REG_W-1:0]     reg_num_q, reg_num_d;
    logic                 bytesel_q, bytesel_d;
    logic [7:0]           bus_data_q, bus_data_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic [7:0]           lo_byte_q, lo_byte_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;
    logic                 advance;
    logic                 wr_cur;
    logic                 byte_done;
    logic [DATA_W-1:0]    sel_data;

    assign advance  = (state_q == ST_IDLE) && (|req_valid_i);
    assign wr_cur   = ~rd_nwr_q;
    assign sel_data = req_data_i[int'(grant_idx)*DATA_W +: DATA_W];

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk         (clk),
        .rst_n       (reset_n),
        .req_i       (req_valid_i),
        .advance_i   (advance),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        busy_d      = busy_q;
        cs_n_d      = cs_n_q;
        rd_nwr_d    = rd_nwr_q;
        reg_num_d   = reg_num_q;
        bytesel_d   = bytesel_q;
        bus_data_d  = bus_data_q;
        ready_d     = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        lo_byte_d   = lo_byte_q;
        id_d        = id_q;
        rdata_d     = rdata_q;
        byte_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (|req_valid_i) begin
                    ready_d    = grant;
                    id_d       = grant_idx;
                    lo_d       = req_byte_i[grant_idx];
                    rd_nwr_d   = ~req_wr_i[grant_idx];
                    reg_num_d  = req_reg_i[int'(grant_idx)*REG_W +: REG_W];
                    bytesel_d  = req_byte_i[grant_idx] ? BYTESEL_LO : BYTESEL_HI;
                    bus_data_d = bus_byte(req_wr_i[grant_idx], req_byte_i[grant_idx], sel_data);
                    lo_byte_d  = sel_data[7:0];
                    rdata_d    = '0;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    state_d    = FIRST_ST;
                    cs_n_d     = FIRST_CS_N;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_STROBE;
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    // Read data is captured at the end of the final strobe cycle.
                    if (!wr_cur) begin
                        if (lo_q) begin
                            rdata_d[7:0] = bus_data_i;
                        end else begin
                            rdata_d[15:8] = bus_data_i;
                        end
                    end
                    cnt_d = '0;
                    if (HOLD_CYC > 0) begin
                        state_d = ST_HOLD;
                        cs_n_d  = 1'b1;
                    end else begin
                        byte_done = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    byte_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (byte_done) begin
            cnt_d = '0;
            if (!lo_q) begin
                lo_d       = 1'b1;
                bytesel_d  = BYTESEL_LO;
                bus_data_d = wr_cur ? lo_byte_q : 8'h00;
                state_d    = FIRST_ST;
                cs_n_d     = FIRST_CS_N;
            end else begin
                state_d     = ST_RESP;
                cs_n_d      = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = wr_cur ? '0 : rdata_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lo_q        <= 1'b0;
            busy_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_nwr_q    <= 1'b1;
            reg_num_q   <= '0;
            bytesel_q   <= 1'b0;
            bus_data_q  <= '0;
            ready_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            cs_n_q      <= cs_n_d;
            rd_nwr_q    <= rd_nwr_d;
            reg_num_q   <= reg_num_d;
            bytesel_q   <= bytesel_d;
            bus_data_q  <= bus_data_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Latched request payload and read assembly; only meaningful while busy.
    always_ff @(posedge clk) begin
        lo_byte_q <= lo_byte_d;
        id_q      <= id_d;
        rdata_q   <= rdata_d;
    end

    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = rsp_id_q;
    assign rsp_data_o    = rsp_data_q;
    assign busy_o        = busy_q;
    assign bus_cs_n_o    = cs_n_q;
    assign bus_rd_nwr_o  = rd_nwr_q;
    assign bus_reg_num_o = reg_num_q;
    assign bus_bytesel_o = bytesel_q;
    assign bus_data_o    = bus_data_q;

endmodule
